vecmat_reduce: RTL and testbench

- Consumer of the 64-lane elementwise product bus produced by the vector-matrix multiplier (one 16-bit signed fixed-point product per lane).
- Sums all 64 lanes in a pipelined adder tree and optionally accumulates several 64-lane beats, for vectors longer than 64 elements.
- Emits one saturated 16-bit dot-product score per in_last beat, with a valid/ready handshake toward the score/softmax stage.

---
 rtl/vecmat_reduce.sv | 182 ++++++++++++++++++
 tb/tb_vecmat_reduce.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmat_reduce.sv
// vecmat_reduce: reduces a LANES-wide signed product bus through a three-level adder
// tree, accumulates multi-beat vectors and emits one saturated score per last beat.
module vecmat_reduce #(
    parameter int LANES     = 64,
    parameter int DW        = 16,
    parameter int ACCW      = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [LANES*DW-1:0] tmp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_sat,
    output logic [7:0]          out_beats
);

    localparam int N1 = LANES / 4;
    localparam int N2 = N1 / 4;
    localparam int W1 = DW + 2;
    localparam int W2 = W1 + 2;
    localparam int W3 = W2 + $clog2(N2);

    localparam logic signed [ACCW-1:0] MAX_V = (ACCW'(1) << (DW - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] MIN_V = ~MAX_V;

    logic adv;
    logic accept;

    logic                 s1_valid_q, s1_last_q;
    logic signed [W1-1:0] s1_sum_q [N1];
    logic signed [W1-1:0] s1_sum_d [N1];

    logic                 s2_valid_q, s2_last_q;
    logic signed [W2-1:0] s2_sum_q [N2];
    logic signed [W2-1:0] s2_sum_d [N2];

    logic                 s3_valid_q, s3_last_q;
    logic signed [W3-1:0] s3_sum_q;
    logic signed [W3-1:0] s3_sum_d;

    logic signed [ACCW-1:0] acc_q, acc_d, acc_next, shifted;
    logic [7:0]             count_q, count_d, count_inc;
    logic                   out_valid_q, out_valid_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic [7:0]             out_beats_q, out_beats_d;
    logic [DW-1:0]          clip_data;
    logic                   clip_sat;

    // A held result stalls the whole pipe; nothing moves until it is taken.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && reset;
    assign accept   = in_valid && in_ready;

    // NOTE: size casts of signed operands sign-extend, so the tree widens exactly.
    always_comb begin
        for (int g = 0; g < N1; g++) begin
            s1_sum_d[g] = '0;
            for (int k = 0; k < 4; k++) begin
                s1_sum_d[g] = s1_sum_d[g] + W1'($signed(tmp[(4*g+k)*DW +: DW]));
            end
        end
    end

    always_comb begin
        for (int g = 0; g < N2; g++) begin
            s2_sum_d[g] = '0;
            for (int k = 0; k < 4; k++) begin
                s2_sum_d[g] = s2_sum_d[g] + W2'(s1_sum_q[4*g+k]);
            end
        end
    end

    always_comb begin
        s3_sum_d = '0;
        for (int g = 0; g < N2; g++) begin
            s3_sum_d = s3_sum_d + W3'(s2_sum_q[g]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every stage
    // samples the pre-edge value of the stage before it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '{default: '0};
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sum_q   <= '{default: '0};
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_sum_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= accept;
            s1_last_q  <= accept && in_last;
            if (accept) begin
                s1_sum_q <= s1_sum_d;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            if (s1_valid_q) begin
                s2_sum_q <= s2_sum_d;
            end
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
            if (s2_valid_q) begin
                s3_sum_q <= s3_sum_d;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_next  = acc_q + ACCW'(s3_sum_q);
        shifted   = acc_next >>> OUT_SHIFT;
        count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
        clip_sat  = 1'b0;
        clip_data = shifted[DW-1:0];
        if (shifted > MAX_V) begin
            clip_sat  = 1'b1;
            clip_data = MAX_V[DW-1:0];
        end else if (shifted < MIN_V) begin
            clip_sat  = 1'b1;
            clip_data = MIN_V[DW-1:0];
        end
    end

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;
        if (adv) begin
            // Under adv a held result is being taken, so valid follows the new load.
            out_valid_d = s3_valid_q && s3_last_q;
            if (s3_valid_q) begin
                if (s3_last_q) begin
                    out_data_d  = clip_data;
                    out_sat_d   = clip_sat;
                    out_beats_d = count_inc;
                    acc_d       = '0;
                    count_d     = '0;
                end else begin
                    acc_d   = acc_next;
                    count_d = count_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_vecmat_reduce.sv
// Directed bench for vecmat_reduce: a queue-based dot-product model checked every
// cycle against two instances (OUT_SHIFT 0 and 4), plus literal expectations.
module tb_vecmat_reduce;

    localparam int LANES = 64;
    localparam int DW    = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [LANES*DW-1:0] tmp;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_sat;
    logic [7:0]          out_beats;

    logic                s_in_ready;
    logic                s_out_valid;
    logic [DW-1:0]       s_out_data;
    logic                s_out_sat;
    logic [7:0]          s_out_beats;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        longint sum;
        int     beats;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] seen[$];
    longint      m_sum   = 0;
    int          m_beats = 0;
    logic [16:0] exp0, exp4;

    always #5 clk = ~clk;

    vecmat_reduce #(.LANES(LANES), .DW(DW), .ACCW(32), .OUT_SHIFT(0)) u_dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .tmp(tmp), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_beats(out_beats)
    );

    vecmat_reduce #(.LANES(LANES), .DW(DW), .ACCW(32), .OUT_SHIFT(4)) u_dut_sh (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .tmp(tmp), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_sat(s_out_sat), .out_beats(s_out_beats)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Score = sum >>> shift, clipped to the signed 16-bit range; {sat, data}.
    function automatic logic [16:0] model_out(input longint s, input int sh);
        longint v;
        v = s >>> sh;
        if (v > 32767)       return {1'b1, 16'h7FFF};
        else if (v < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, 16'(v)};
    endfunction

    // Model and compare at the falling edge, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum   = 0;
            m_beats = 0;
            exp_q.delete();
        end else begin
            check("shift_valid_align", s_out_valid, out_valid);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", out_valid, 1'b0);
                end else begin
                    exp0 = model_out(exp_q[0].sum, 0);
                    exp4 = model_out(exp_q[0].sum, 4);
                    check("data", out_data, exp0[15:0]);
                    check("sat", out_sat, exp0[16]);
                    check("beats", out_beats, exp_q[0].beats);
                    check("sh_data", s_out_data, exp4[15:0]);
                    check("sh_sat", s_out_sat, exp4[16]);
                    check("sh_beats", s_out_beats, exp_q[0].beats);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen.push_back(out_data);
                    end
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < LANES; i++) m_sum += longint'($signed(tmp[i*16 +: 16]));
                m_beats++;
                if (in_last) begin
                    exp_q.push_back('{sum: m_sum, beats: (m_beats > 255) ? 255 : m_beats});
                    m_sum   = 0;
                    m_beats = 0;
                end
            end
        end
    end

    // Even lanes carry a, odd lanes b; returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        bit ok = 1'b0;
        for (int i = 0; i < LANES; i++) tmp[i*16 +: 16] = (i % 2 == 0) ? a : b;
        in_valid = 1'b1;
        in_last  = last;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accept", ok, 1'b1);
    endtask

    task automatic expect_result(input string name, input logic [15:0] d, input logic s,
                                 input logic [7:0] b, input logic [15:0] sd, input logic ss);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_data"}, out_data, d);
        check({name, "_sat"}, out_sat, s);
        check({name, "_beats"}, out_beats, b);
        check({name, "_sh_data"}, s_out_data, sd);
        check({name, "_sh_sat"}, s_out_sat, ss);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_out_data"}, out_data, 16'h0000);
        check({name, "_out_sat"}, out_sat, 1'b0);
        check({name, "_out_beats"}, out_beats, 8'h00);
        check({name, "_in_ready"}, in_ready, 1'b0);
        check({name, "_sh_out_valid"}, s_out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tmp       = '0;
        out_ready = 1'b1;

        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Single last beat of ones: first valid after the third edge past accept.
        send(16'h0001, 16'h0001, 1'b1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_edges", lat, 3);
        check("ones_data", out_data, 16'h0040);
        check("ones_sat", out_sat, 1'b0);
        check("ones_beats", out_beats, 8'd1);
        @(posedge clk);
        #1;
        check("ones_single_cycle", out_valid, 1'b0);

        // Saturation corners and a cancelling pattern.
        send(16'h7FFF, 16'h7FFF, 1'b1);
        in_valid = 1'b0;
        expect_result("pos_sat", 16'h7FFF, 1'b1, 8'd1, 16'h7FFF, 1'b1);
        send(16'h8000, 16'h8000, 1'b1);
        in_valid = 1'b0;
        expect_result("neg_sat", 16'h8000, 1'b1, 8'd1, 16'h8000, 1'b1);
        send(16'h7FFF, 16'h8001, 1'b1);
        in_valid = 1'b0;
        expect_result("alt_zero", 16'h0000, 1'b0, 8'd1, 16'h0000, 1'b0);

        // Multi-beat accumulation, then a fresh dot product with no gap.
        send(16'h0001, 16'h0001, 1'b0);
        send(16'h0001, 16'h0001, 1'b0);
        send(16'h0001, 16'h0001, 1'b1);
        send(16'h0002, 16'h0002, 1'b1);
        in_valid = 1'b0;
        expect_result("three_beats", 16'h00C0, 1'b0, 8'd3, 16'h000C, 1'b0);
        expect_result("after_three", 16'h0080, 1'b0, 8'd1, 16'h0008, 1'b0);

        // Shifted instance: 64 * 256 = 16384, >>> 4 = 1024.
        send(16'h0100, 16'h0100, 1'b1);
        in_valid = 1'b0;
        expect_result("shift4", 16'h4000, 1'b0, 8'd1, 16'h0400, 1'b0);

        // Back-pressure: six continuous last beats, result held for 5 cycles.
        repeat (3) @(posedge clk);
        #1;
        seen.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send(16'(k), 16'(k), 1'b1);
                in_valid = 1'b0;
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_first_valid", out_valid, 1'b1);
                for (int c = 0; c < 5; c++) begin
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_hold_data", out_data, 16'h0040);
                    check("stall_hold_valid", out_valid, 1'b1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("stall_result_count", seen.size(), 6);
        for (int i = 0; i < seen.size() && i < 6; i++) begin
            check("stall_order", seen[i], 16'(64 * (i + 1)));
        end

        // Reset mid-accumulation discards the partial sum.
        send(16'h0001, 16'h0001, 1'b0);
        send(16'h0001, 16'h0001, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        send(16'h0001, 16'h0001, 1'b1);
        in_valid = 1'b0;
        expect_result("post_reset", 16'h0040, 1'b0, 8'd1, 16'h0004, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("model_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
